// File: rtl/hack_trace_pkg.sv
// Shared types, mode constants and record-layout helpers for the Hack CPU trace recorder.
package hack_trace_pkg;

  // Capture FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_READ  = 2'd3
  } trace_state_e;

  // Trigger modes
  localparam logic [1:0] TRIG_IMM = 2'd0;  // first sample after arm
  localparam logic [1:0] TRIG_PC  = 2'd1;  // pc_in == trig_val[PC_W-1:0]
  localparam logic [1:0] TRIG_DWR = 2'd2;  // D-register write strobe
  localparam logic [1:0] TRIG_ALU = 2'd3;  // alu_in == trig_val

  // ctrl_bus bit positions
  localparam int CTRL_WE_A = 0;
  localparam int CTRL_WE_M = 1;
  localparam int CTRL_WE_D = 2;
  localparam int CTRL_PC_E = 3;
  localparam int CTRL_A    = 4;

  // Default geometry of the Hack core taps
  localparam int DEF_PC_W    = 15;
  localparam int DEF_INSTR_W = 16;
  localparam int DEF_DATA_W  = 16;
  localparam int DEF_CTRL_W  = 5;
  localparam int DEF_DEPTH   = 64;

  // Record is {pc, instr, ctrl, alu, cout}, cout in bit 0
  localparam int COUT_LSB = 0;
  localparam int ALU_LSB  = 1;

  function automatic int rec_w(input int pc_w, input int instr_w, input int ctrl_w, input int data_w);
    return pc_w + instr_w + ctrl_w + data_w + 1;
  endfunction

  function automatic int ctrl_lsb(input int data_w);
    return data_w + 1;
  endfunction

  function automatic int instr_lsb(input int ctrl_w, input int data_w);
    return ctrl_w + data_w + 1;
  endfunction

  function automatic int pc_lsb(input int instr_w, input int ctrl_w, input int data_w);
    return instr_w + ctrl_w + data_w + 1;
  endfunction

endpackage

// File: rtl/trace_ram.sv
// Simple dual-port record store: one write port, one synchronous read port with a
// holding output register (keeps its value when no read is issued, clearable).
module trace_ram #(
  parameter  int DEPTH = 64,
  parameter  int REC_W = 53,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [REC_W-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  input  logic             rclr,
  output logic [REC_W-1:0] rdata
);

  logic [REC_W-1:0] mem_q [DEPTH];
  logic [REC_W-1:0] rdata_q;
  logic [REC_W-1:0] rdata_d;

  // Write port: store a record when enabled
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Read-data next value: clear wins, then a fresh read, else hold
  always_comb begin
    rdata_d = rdata_q;
    if (rclr) begin
      rdata_d = '0;
    end else if (re) begin
      rdata_d = mem_q[raddr];
    end else begin
      rdata_d = rdata_q;
    end
  end

  // Read-data output register
  always_ff @(posedge clk) begin
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/hack_trace_buffer.sv
// Trigger-based circular trace recorder for the Hack CPU. Records {pc,instr,ctrl,alu,cout}
// on retired cycles, keeps pre-trigger history plus a post-trigger window, then drains
// oldest-first over a valid/ready port.
module hack_trace_buffer
  import hack_trace_pkg::*;
#(
  parameter  int PC_W    = DEF_PC_W,
  parameter  int INSTR_W = DEF_INSTR_W,
  parameter  int DATA_W  = DEF_DATA_W,
  parameter  int CTRL_W  = DEF_CTRL_W,
  parameter  int DEPTH   = DEF_DEPTH,
  localparam int AW      = $clog2(DEPTH),
  localparam int REC_W   = rec_w(PC_W, INSTR_W, CTRL_W, DATA_W)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               smp_valid,
  input  logic [PC_W-1:0]    pc_in,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic [CTRL_W-1:0]  ctrl_in,
  input  logic [DATA_W-1:0]  alu_in,
  input  logic               cout_in,
  input  logic               arm,
  input  logic               abort,
  input  logic [1:0]         trig_mode,
  input  logic [DATA_W-1:0]  trig_val,
  input  logic [AW-1:0]      post_cnt,
  output logic               busy,
  output logic               triggered,
  output logic               rd_valid,
  input  logic               rd_ready,
  output logic [REC_W-1:0]   rd_data,
  output logic               rd_last
);

  localparam logic [AW:0]   FILL_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1'b1);
  localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1'b1);

  trace_state_e state_q, state_d;

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW:0]       fill_q, fill_d;
  logic [AW-1:0]     remain_q, remain_d;
  logic [AW-1:0]     post_q, post_d;
  logic [1:0]        mode_q, mode_d;
  logic [DATA_W-1:0] tval_q, tval_d;
  logic              triggered_q, triggered_d;
  logic              busy_q, busy_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       rd_left_q, rd_left_d;
  logic              rd_valid_q, rd_valid_d;
  logic              rd_last_q, rd_last_d;

  logic              trig_hit_s;
  logic              capturing_s;
  logic              wr_en_s;
  logic              enter_read_s;
  logic              rd_fetch_s;
  logic              rd_hs_s;
  logic              rd_clr_s;
  logic [REC_W-1:0]  rec_s;
  logic [REC_W-1:0]  ram_rdata_s;

  assign rec_s        = {pc_in, instr_in, ctrl_in, alu_in, cout_in};
  assign capturing_s  = (state_q == ST_ARMED) || (state_q == ST_POST);
  assign wr_en_s      = smp_valid && capturing_s && !abort;
  assign rd_hs_s      = (state_q == ST_READ) && rd_valid_q && rd_ready;
  assign rd_fetch_s   = (state_q == ST_READ) && (rd_left_q != '0) && (!rd_valid_q || rd_ready);
  assign enter_read_s = (state_q != ST_READ) && (state_d == ST_READ);

  // Trigger comparator against the current sample using the latched mode/value
  always_comb begin
    trig_hit_s = 1'b0;
    case (mode_q)
      TRIG_IMM: trig_hit_s = 1'b1;
      TRIG_PC:  trig_hit_s = (pc_in == tval_q[PC_W-1:0]);
      TRIG_DWR: trig_hit_s = ctrl_in[CTRL_WE_D];
      TRIG_ALU: trig_hit_s = (alu_in == tval_q);
      default:  trig_hit_s = 1'b0;
    endcase
  end

  // FSM next state; abort overrides everything including a simultaneous arm
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (arm) begin
            state_d = ST_ARMED;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_ARMED: begin
          if (smp_valid && trig_hit_s) begin
            state_d = (post_q == '0) ? ST_READ : ST_POST;
          end else begin
            state_d = ST_ARMED;
          end
        end
        ST_POST: begin
          if (smp_valid && (remain_q == PTR_ONE)) begin
            state_d = ST_READ;
          end else begin
            state_d = ST_POST;
          end
        end
        ST_READ: begin
          if (rd_hs_s && rd_last_q) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_READ;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // FSM outputs: busy follows the next state, triggered is sticky until IDLE
  always_comb begin
    busy_d      = (state_d == ST_ARMED) || (state_d == ST_POST);
    triggered_d = triggered_q;
    if (state_d == ST_IDLE) begin
      triggered_d = 1'b0;
    end else if ((state_q == ST_ARMED) && smp_valid && trig_hit_s) begin
      triggered_d = 1'b1;
    end else begin
      triggered_d = triggered_q;
    end
  end

  // Capture side: arm setup, write pointer, fill level and post-window countdown
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    fill_d   = fill_q;
    remain_d = remain_q;
    post_d   = post_q;
    mode_d   = mode_q;
    tval_d   = tval_q;
    if (abort) begin
      wr_ptr_d = '0;
      fill_d   = '0;
      remain_d = '0;
    end else if ((state_q == ST_IDLE) && arm) begin
      wr_ptr_d = '0;
      fill_d   = '0;
      remain_d = '0;
      post_d   = post_cnt;
      mode_d   = trig_mode;
      tval_d   = trig_val;
    end else if (wr_en_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
      fill_d   = (fill_q == FILL_FULL) ? fill_q : (fill_q + CNT_ONE);
      // In ARMED the countdown is preloaded so a trigger enters POST with the full window
      remain_d = (state_q == ST_ARMED) ? post_q : (remain_q - PTR_ONE);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
  end

  // Read side: prefetch from the oldest slot, hold under backpressure, no bubbles
  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    rd_left_d  = rd_left_q;
    rd_valid_d = rd_valid_q;
    rd_last_d  = rd_last_q;
    rd_clr_s   = 1'b0;
    if (abort) begin
      rd_ptr_d   = '0;
      rd_left_d  = '0;
      rd_valid_d = 1'b0;
      rd_last_d  = 1'b0;
      rd_clr_s   = 1'b1;
    end else if (enter_read_s) begin
      // Oldest record sits fill slots behind the final write pointer
      rd_ptr_d   = wr_ptr_d - fill_d[AW-1:0];
      rd_left_d  = fill_d;
      rd_valid_d = 1'b0;
      rd_last_d  = 1'b0;
    end else if (rd_fetch_s) begin
      rd_ptr_d   = rd_ptr_q + PTR_ONE;
      rd_left_d  = rd_left_q - CNT_ONE;
      rd_valid_d = 1'b1;
      rd_last_d  = (rd_left_q == CNT_ONE);
    end else if (rd_hs_s) begin
      rd_valid_d = 1'b0;
      rd_last_d  = 1'b0;
      rd_clr_s   = 1'b1;
    end else begin
      rd_valid_d = rd_valid_q;
    end
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      fill_q      <= '0;
      remain_q    <= '0;
      post_q      <= '0;
      mode_q      <= TRIG_IMM;
      tval_q      <= '0;
      triggered_q <= 1'b0;
      busy_q      <= 1'b0;
      rd_ptr_q    <= '0;
      rd_left_q   <= '0;
      rd_valid_q  <= 1'b0;
      rd_last_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      fill_q      <= fill_d;
      remain_q    <= remain_d;
      post_q      <= post_d;
      mode_q      <= mode_d;
      tval_q      <= tval_d;
      triggered_q <= triggered_d;
      busy_q      <= busy_d;
      rd_ptr_q    <= rd_ptr_d;
      rd_left_q   <= rd_left_d;
      rd_valid_q  <= rd_valid_d;
      rd_last_q   <= rd_last_d;
    end
  end

  trace_ram #(
    .DEPTH (DEPTH),
    .REC_W (REC_W)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en_s),
    .waddr (wr_ptr_q),
    .wdata (rec_s),
    .re    (rd_fetch_s),
    .raddr (rd_ptr_q),
    .rclr  (reset || rd_clr_s),
    .rdata (ram_rdata_s)
  );

  assign busy      = busy_q;
  assign triggered = triggered_q;
  assign rd_valid  = rd_valid_q;
  assign rd_last   = rd_last_q;
  assign rd_data   = ram_rdata_s;

endmodule
